// File: rtl/spike_packet_receiver.sv
// Spike packet receiver: input FIFO, per-neuron own-address/synapse match, one accumulate command per packet.
// Define RX_DROP_COUNT_EN to build the saturating dropped-packet counter; otherwise drop_count is tied to 0.

module spike_rx_entry #(
    parameter int ADDR_W    = 12,
    parameter int SYN_SLOTS = 3,
    parameter int WEIGHT_W  = 16,
    parameter int SLOT_W    = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                we,
    input  logic [SLOT_W-1:0]   slot,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [ADDR_W-1:0]   dst,
    input  logic [ADDR_W-1:0]   src,
    output logic                own_hit,
    output logic                syn_hit,
    output logic [WEIGHT_W-1:0] syn_weight
);
    logic [ADDR_W-1:0]                  own_addr;
    logic                               own_v;
    logic [SYN_SLOTS-1:0][ADDR_W-1:0]   syn_src;
    logic [SYN_SLOTS-1:0][WEIGHT_W-1:0] syn_w;
    logic [SYN_SLOTS-1:0]               syn_v;

    // All-ones slot code selects the neuron's own address.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            own_addr <= '0;
            own_v    <= 1'b0;
            syn_src  <= '0;
            syn_w    <= '0;
            syn_v    <= '0;
        end else if (we) begin
            if (&slot) begin
                own_addr <= addr;
                own_v    <= 1'b1;
            end else if (int'(slot) < SYN_SLOTS) begin
                syn_src[slot] <= addr;
                syn_w[slot]   <= weight;
                syn_v[slot]   <= 1'b1;
            end
        end
    end

    assign own_hit = own_v && (own_addr == dst);

    always_comb begin
        syn_hit    = 1'b0;
        syn_weight = '0;
        for (int s = SYN_SLOTS - 1; s >= 0; s--) begin
            if (syn_v[s] && (syn_src[s] == src)) begin
                syn_hit    = 1'b1;
                syn_weight = syn_w[s];
            end
        end
    end
endmodule

module spike_packet_receiver #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int SYN_SLOTS   = 3,
    parameter int WEIGHT_W    = 16,
    parameter int FIFO_DEPTH  = 4,
    localparam int IDX_W      = $clog2(NUM_NEURONS),
    localparam int PKT_W      = 2 * ADDR_W,
    localparam int SLOT_W     = $clog2(SYN_SLOTS + 1)
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PKT_W-1:0]    in_packet,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_neuron,
    input  logic [SLOT_W-1:0]   cfg_slot,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic                busy,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic [IDX_W-1:0]    acc_neuron,
    output logic [WEIGHT_W-1:0] acc_weight,
    output logic [15:0]         drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MATCH  = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_EMIT   = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
    } pkt_t;

    logic [1:0] state;
    pkt_t       pkt;
    logic [IDX_W-1:0] hit_idx;

    // Input FIFO
    logic [FIFO_DEPTH-1:0][PKT_W-1:0] fifo_mem;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= in_packet;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

    // Per-neuron config table and comparators
    logic                                 cfg_ok;
    logic [NUM_NEURONS-1:0]               own_hit;
    logic [NUM_NEURONS-1:0]               syn_hit;
    logic [NUM_NEURONS-1:0][WEIGHT_W-1:0] nrn_w;

    assign cfg_ok = cfg_we && !busy && (int'(cfg_neuron) < NUM_NEURONS);

    generate
        for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_nrn
            spike_rx_entry #(
                .ADDR_W(ADDR_W), .SYN_SLOTS(SYN_SLOTS), .WEIGHT_W(WEIGHT_W), .SLOT_W(SLOT_W)
            ) u_entry (
                .CLK        (CLK),
                .RESET_N    (RESET_N),
                .we         (cfg_ok && (cfg_neuron == IDX_W'(g))),
                .slot       (cfg_slot),
                .addr       (cfg_addr),
                .weight     (cfg_weight),
                .dst        (pkt.dst),
                .src        (pkt.src),
                .own_hit    (own_hit[g]),
                .syn_hit    (syn_hit[g]),
                .syn_weight (nrn_w[g])
            );
        end
    endgenerate

    logic             any_own;
    logic [IDX_W-1:0] match_idx;
    logic             lk_hit;
    logic [WEIGHT_W-1:0] lk_w;

    // Lowest matching neuron index wins.
    always_comb begin
        match_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (own_hit[i]) match_idx = IDX_W'(i);
        end
    end

    assign any_own = |own_hit;
    assign lk_hit  = syn_hit[hit_idx];
    assign lk_w    = nrn_w[hit_idx];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            pkt        <= '0;
            hit_idx    <= '0;
            acc_neuron <= '0;
            acc_weight <= '0;
        end else begin
            case (state)
                S_IDLE: if (!fifo_empty) begin
                    pkt   <= fifo_mem[rd_ptr];
                    state <= S_MATCH;
                end
                S_MATCH: if (any_own) begin
                    hit_idx <= match_idx;
                    state   <= S_LOOKUP;
                end else begin
                    state <= S_IDLE;
                end
                S_LOOKUP: if (lk_hit) begin
                    acc_neuron <= hit_idx;
                    acc_weight <= lk_w;
                    state      <= S_EMIT;
                end else begin
                    state <= S_IDLE;
                end
                S_EMIT: if (acc_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign acc_valid = (state == S_EMIT);

`ifdef RX_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = ((state == S_MATCH) && !any_own) || ((state == S_LOOKUP) && !lk_hit);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                  drop_cnt <= '0;
        else if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_spike_packet_receiver.sv
// Bench for spike_packet_receiver: directed scenarios plus randomized traffic against a table-lookup model.
module tb_spike_packet_receiver;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        in_valid, in_ready;
    logic [23:0] in_packet;
    logic        cfg_we;
    logic [3:0]  cfg_neuron;
    logic [1:0]  cfg_slot;
    logic [11:0] cfg_addr;
    logic [15:0] cfg_weight;
    logic        busy, acc_valid, acc_ready;
    logic [3:0]  acc_neuron;
    logic [15:0] acc_weight, drop_count;

    spike_packet_receiver dut (
        .CLK(CLK), .RESET_N(RESET_N), .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot), .cfg_addr(cfg_addr),
        .cfg_weight(cfg_weight), .busy(busy), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_neuron(acc_neuron), .acc_weight(acc_weight), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_hs  = 0;
    always @(posedge CLK) cyc++;

    // Reference model: the configuration table and expected command stream.
    logic [11:0] m_own   [10];
    bit          m_own_v [10];
    logic [11:0] m_src   [10][3];
    logic [15:0] m_w     [10][3];
    bit          m_syn_v [10][3];
    typedef struct { int n; logic [15:0] w; } cmd_t;
    cmd_t expq[$];
    int   m_drops = 0;

    function automatic void model_clear();
        for (int i = 0; i < 10; i++) begin
            m_own_v[i] = 0;
            for (int s = 0; s < 3; s++) m_syn_v[i][s] = 0;
        end
        expq.delete();
        m_drops = 0;
    endfunction

    function automatic void resolve(input logic [23:0] p, output bit hit, output int n, output logic [15:0] w);
        hit = 0; n = -1; w = '0;
        for (int i = 0; i < 10 && n < 0; i++)
            if (m_own_v[i] && m_own[i] == p[11:0]) n = i;
        if (n >= 0)
            for (int s = 0; s < 3 && !hit; s++)
                if (m_syn_v[n][s] && m_src[n][s] == p[23:12]) begin hit = 1; w = m_w[n][s]; end
    endfunction

    function automatic int exp_drops();
`ifdef RX_DROP_COUNT_EN
        return (m_drops > 65535) ? 65535 : m_drops;
`else
        return 0;
`endif
    endfunction

    // Monitor: accepted packets feed the model, handshakes are checked against it.
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (in_valid && in_ready) begin
                bit hit; int n; logic [15:0] w;
                resolve(in_packet, hit, n, w);
                if (hit) expq.push_back('{n, w});
                else     m_drops++;
            end
            if (acc_valid && acc_ready) begin
                n_hs++;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd got neuron=%0d weight=%h, required none", acc_neuron, acc_weight);
                end else begin
                    cmd_t e;
                    e = expq.pop_front();
                    if (acc_neuron !== 4'(e.n) || acc_weight !== e.w) begin
                        bad++;
                        $display("FAIL cmd got neuron=%0d weight=%h, required neuron=%0d weight=%h",
                                 acc_neuron, acc_weight, e.n, e.w);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic cfg_write(input int n, input int slot, input logic [11:0] a, input logic [15:0] w, input bit apply_model);
        cfg_we = 1; cfg_neuron = 4'(n); cfg_slot = 2'(slot); cfg_addr = a; cfg_weight = w;
        tick();
        cfg_we = 0;
        if (apply_model && n < 10) begin
            if (slot == 3) begin m_own[n] = a; m_own_v[n] = 1; end
            else begin m_src[n][slot] = a; m_w[n][slot] = w; m_syn_v[n][slot] = 1; end
        end
    endtask

    task automatic send(input logic [23:0] p);
        in_valid = 1; in_packet = p;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (!busy && !acc_valid) ok = 1;
            else tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s_idle_timeout busy=%b acc_valid=%b, required idle", tag, busy, acc_valid); end
    endtask

    task automatic test_reset();
        RESET_N = 0; in_valid = 0; in_packet = '0; cfg_we = 0; cfg_neuron = '0; cfg_slot = '0;
        cfg_addr = '0; cfg_weight = '0; acc_ready = 0;
        model_clear();
        repeat (3) tick();
        total += 6;
        if (acc_valid !== 1'b0)      begin bad++; $display("FAIL reset_acc_valid got=%b required=0", acc_valid); end
        if (acc_neuron !== 4'd0)     begin bad++; $display("FAIL reset_acc_neuron got=%0d required=0", acc_neuron); end
        if (acc_weight !== 16'd0)    begin bad++; $display("FAIL reset_acc_weight got=%h required=0", acc_weight); end
        if (drop_count !== 16'd0)    begin bad++; $display("FAIL reset_drop_count got=%0d required=0", drop_count); end
        if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
        if (in_ready !== 1'b1)       begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        @(negedge CLK); RESET_N = 1;
        tick();
    endtask

    task automatic test_latency();
        cfg_write(2, 3, 12'h012, 16'h0, 1);
        cfg_write(2, 1, 12'h0A5, 16'h0040, 1);
        acc_ready = 1;
        send(24'h0A5012);                       // edge k
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy_k got=%b required=1", busy); end
        tick();                                 // k+1
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_k1 got=%b required=0", acc_valid); end
        tick();                                 // k+2
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_k2 got=%b required=0", acc_valid); end
        tick();                                 // k+3
        total += 3;
        if (acc_valid !== 1'b1)    begin bad++; $display("FAIL lat_valid_k3 got=%b required=1", acc_valid); end
        if (acc_neuron !== 4'd2)   begin bad++; $display("FAIL lat_neuron got=%0d required=2", acc_neuron); end
        if (acc_weight !== 16'h40) begin bad++; $display("FAIL lat_weight got=%h required=0040", acc_weight); end
        tick();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_k4 got=%b required=0", acc_valid); end
        wait_idle("latency");
    endtask

    task automatic test_drop();
        send(24'h0A5999);                       // no local destination
        tick();                                 // k+1: MATCH
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_k1 got=%b required=1", busy); end
        tick();                                 // k+2: back in IDLE
        total += 3;
        if (busy !== 1'b0)      begin bad++; $display("FAIL drop_busy_k2 got=%b required=0", busy); end
        if (acc_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b required=0", acc_valid); end
        if (drop_count !== 16'(exp_drops())) begin bad++; $display("FAIL drop_count_match got=%0d required=%0d", drop_count, exp_drops()); end
        send(24'h0A6012);                       // dst hits neuron 2, src misses
        tick(); tick();                         // k+2: LOOKUP
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_lookup_busy got=%b required=1", busy); end
        tick();                                 // k+3: dropped
        total += 3;
        if (busy !== 1'b0)      begin bad++; $display("FAIL drop_lookup_idle got=%b required=0", busy); end
        if (acc_valid !== 1'b0) begin bad++; $display("FAIL drop_lookup_valid got=%b required=0", acc_valid); end
        if (drop_count !== 16'(exp_drops())) begin bad++; $display("FAIL drop_count_lookup got=%0d required=%0d", drop_count, exp_drops()); end
    endtask

    task automatic test_priority();
        cfg_write(3, 3, 12'h020, 16'h0, 1);
        cfg_write(7, 3, 12'h020, 16'h0, 1);
        cfg_write(7, 0, 12'h111, 16'h1234, 1);
        cfg_write(3, 2, 12'h111, 16'h7777, 1);
        cfg_write(3, 0, 12'h111, 16'hFFF0, 1);
        acc_ready = 0;
        send(24'h111020);
        repeat (4) tick();
        total += 3;
        if (acc_valid !== 1'b1)      begin bad++; $display("FAIL prio_valid got=%b required=1", acc_valid); end
        if (acc_neuron !== 4'd3)     begin bad++; $display("FAIL prio_neuron got=%0d required=3", acc_neuron); end
        if (acc_weight !== 16'hFFF0) begin bad++; $display("FAIL prio_weight got=%h required=fff0", acc_weight); end
        acc_ready = 1;
        wait_idle("priority");
    endtask

    task automatic test_back_to_back();
        logic [23:0] p [6];
        int n_acc = 0;
        int hs_t[$];
        cfg_write(2, 0, 12'h0B0, 16'h0011, 1);
        cfg_write(2, 2, 12'h0C0, 16'h0022, 1);
        p = '{24'h0B0012, 24'h0A5012, 24'h111020, 24'h0C0012, 24'h0A5012, 24'h0B0012};
        acc_ready = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_packet = p[i];
            @(negedge CLK);
            if (in_ready) n_acc++;
            tick();
        end
        in_valid = 0;
        repeat (3) tick();
        total += 4;
        if (n_acc !== 5)          begin bad++; $display("FAIL b2b_accepted got=%0d required=5", n_acc); end
        if (in_ready !== 1'b0)    begin bad++; $display("FAIL b2b_in_ready got=%b required=0", in_ready); end
        if (acc_valid !== 1'b1)   begin bad++; $display("FAIL b2b_stall_valid got=%b required=1", acc_valid); end
        if (acc_weight !== 16'h0011) begin bad++; $display("FAIL b2b_stall_weight got=%h required=0011", acc_weight); end
        acc_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (acc_valid && acc_ready) hs_t.push_back(cyc);
        end
        total++;
        if (hs_t.size() != 5) begin bad++; $display("FAIL b2b_cmd_count got=%0d required=5", hs_t.size()); end
        for (int i = 1; i < hs_t.size(); i++) begin
            total++;
            if (hs_t[i] - hs_t[i-1] != 4) begin bad++; $display("FAIL b2b_spacing got=%0d required=4", hs_t[i] - hs_t[i-1]); end
        end
        tick();
        wait_idle("b2b");
    endtask

    task automatic test_cfg_busy();
        acc_ready = 0;
        send(24'h0A5012);
        tick(); tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL cfgbusy_busy got=%b required=1", busy); end
        cfg_write(5, 3, 12'h055, 16'h0, 0);
        cfg_write(2, 1, 12'h0A5, 16'h9999, 0);
        acc_ready = 1;
        wait_idle("cfgbusy_a");
        send(24'h0A5055);
        wait_idle("cfgbusy_b");
        send(24'h0A5012);
        wait_idle("cfgbusy_c");
        total += 2;
        if (drop_count !== 16'(exp_drops())) begin bad++; $display("FAIL cfgbusy_drops got=%0d required=%0d", drop_count, exp_drops()); end
        if (expq.size() != 0) begin bad++; $display("FAIL cfgbusy_pending got=%0d required=0", expq.size()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            cfg_write($urandom_range(0, 11), $urandom_range(0, 3),
                      ($urandom_range(0, 1) != 0) ? 12'(12'h100 + $urandom_range(0, 3)) : 12'(12'h200 + $urandom_range(0, 3)),
                      16'($urandom), 1);
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_packet = {12'(12'h200 + $urandom_range(0, 4)), 12'(12'h100 + $urandom_range(0, 4))};
            acc_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid = 0; acc_ready = 1;
        wait_idle("random");
        total += 2;
        if (expq.size() != 0) begin bad++; $display("FAIL random_pending got=%0d required=0", expq.size()); end
        if (drop_count !== 16'(exp_drops())) begin bad++; $display("FAIL random_drops got=%0d required=%0d", drop_count, exp_drops()); end
    endtask

    task automatic test_reset_mid();
        int hs0;
        bit seen = 0;
        cfg_write(2, 3, 12'h012, 16'h0, 1);
        cfg_write(2, 1, 12'h0A5, 16'h0040, 1);
        acc_ready = 0;
        in_valid = 1; in_packet = 24'h0A5012;
        repeat (3) tick();
        in_valid = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (acc_valid) seen = 1; else tick();
        end
        total += 2;
        if (!seen)           begin bad++; $display("FAIL rstmid_emit_timeout got=0 required=1"); end
        if (busy !== 1'b1)   begin bad++; $display("FAIL rstmid_busy_before got=%b required=1", busy); end
        #2 RESET_N = 0;
        model_clear();
        #1;
        total += 5;
        if (acc_valid !== 1'b0)   begin bad++; $display("FAIL rstmid_valid got=%b required=0", acc_valid); end
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL rstmid_in_ready got=%b required=1", in_ready); end
        if (busy !== 1'b0)        begin bad++; $display("FAIL rstmid_busy got=%b required=0", busy); end
        if (acc_neuron !== 4'd0)  begin bad++; $display("FAIL rstmid_neuron got=%0d required=0", acc_neuron); end
        if (drop_count !== 16'd0) begin bad++; $display("FAIL rstmid_drops got=%0d required=0", drop_count); end
        @(negedge CLK); RESET_N = 1; acc_ready = 1;
        hs0 = n_hs;
        repeat (20) tick();
        total += 2;
        if (n_hs != hs0)        begin bad++; $display("FAIL rstmid_cmds got=%0d required=0", n_hs - hs0); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy_after got=%b required=0", busy); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drop();
        test_priority();
        test_back_to_back();
        test_cfg_busy();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spike_packet_receiver.md
# spike_packet_receiver

Receive-side counterpart of the tile's spike packet transmitter. Accepts 24-bit spike packets {source address[23:12], destination address[11:0]} from the NoC, buffers them in a small FIFO, resolves the destination to a local neuron index, looks up the synaptic weight for the source address, and issues one accumulate command per packet to the neuron accumulators. Packets with no local destination or no matching synapse are dropped.

## Interface
- NUM_NEURONS, 10, local neurons; index width 4
- ADDR_W, 12, neuron address width; packet width 2*ADDR_W
- SYN_SLOTS, 3, upstream synapse slots per neuron
- WEIGHT_W, 16, signed synaptic weight width
- FIFO_DEPTH, 4, input FIFO entries; power of two
- CLK  input  1  clock; all state updates on rising edge
- RESET_N  input  1  reset, asynchronous, active-low
- in_valid  input  1  packet present on in_packet
- in_ready  output  1  FIFO can accept; high iff FIFO not full
- in_packet  input  24  {src[23:12], dst[11:0]}
- cfg_we  input  1  configuration write strobe
- cfg_neuron  input  4  neuron index for write
- cfg_slot  input  2  0..SYN_SLOTS-1 = synapse slot; 3 = neuron's own address
- cfg_addr  input  12  address written (source address or own address)
- cfg_weight  input  16  weight written (ignored for slot 3)
- busy  output  1  high when FSM not IDLE or FIFO not empty
- acc_valid  output  1  accumulate command valid
- acc_ready  input  1  accumulator accepts command
- acc_neuron  output  4  target neuron index
- acc_weight  output  16  signed weight to add
- drop_count  output  16  dropped-packet counter (see Configuration)

## Operation
- Config table: per neuron one own-address entry plus SYN_SLOTS {src addr, weight, valid} entries. A write sets the entry's valid bit. cfg_we applied only when busy=0; ignored otherwise. cfg_neuron >= NUM_NEURONS ignored.
- FIFO: push on in_valid & in_ready. in_ready = !full; no same-cycle push-through when full, even if popping.
- FSM states IDLE, MATCH, LOOKUP, EMIT:
  - IDLE: if FIFO non-empty, pop into packet register -> MATCH.
  - MATCH: parallel compare dst against all valid own-address entries. Lowest matching index wins. Hit -> LOOKUP. Miss -> drop, IDLE.
  - LOOKUP: compare src against the hit neuron's valid synapse slots. Lowest matching slot wins. Register index and weight. Hit -> EMIT. Miss -> drop, IDLE.
  - EMIT: acc_valid=1. acc_neuron and acc_weight stay stable until acc_valid & acc_ready, then IDLE.
- Weight is passed through unmodified; no arithmetic in this block.

## Timing
- Reset: FIFO empty, FSM IDLE, all table valid bits 0, acc_valid=0, acc_neuron=0, acc_weight=0, drop_count=0, busy=0, in_ready=1.
- Latency: packet accepted at edge k. Popped at k+1. MATCH resolved at k+2. acc_valid high from edge k+3.
- Peak throughput: one packet per 4 cycles with acc_ready held high.
- Drop decisions take effect at the MATCH or LOOKUP edge. The FSM returns to IDLE on the same edge.
- acc_ready low stalls EMIT indefinitely. The FIFO keeps accepting until full.
- RESET_N asserted mid-operation immediately returns all state to reset values. FIFO contents and the in-flight packet are discarded.

## Configuration
- RX_DROP_COUNT_EN defined:
  - drop_count increments by 1 on each drop (MATCH or LOOKUP miss).
  - Saturates at 0xFFFF.
- RX_DROP_COUNT_EN undefined:
  - No counter logic; drop_count tied to 0.
  - Dropping behaviour is otherwise identical.

## Test plan
- Own address of neuron 2 = 0x012; neuron 2 slot 1 = {0x0A5, weight 0x0040}. Send 0x0A5012 at edge k -> acc_valid at k+3 with acc_neuron=2, acc_weight=0x0040.
- Send 0x0A5999 (no local dst) -> no acc_valid. drop_count=1 with RX_DROP_COUNT_EN defined, 0 without. FSM back in IDLE at k+2.
- Neurons 3 and 7 both given own address 0x020; neuron 3 slot 0 = {0x111, 0xFFF0}. Send 0x111020 -> acc_neuron=3, acc_weight=0xFFF0.
- acc_ready held low; push 6 packets back-to-back:
  - in_ready drops after 1 packet in EMIT plus 4 buffered.
  - Release acc_ready -> 5 commands emitted in order, 4 cycles apart.
- cfg_we pulsed while busy=1 -> table unchanged; a later packet to that entry is dropped.
- RESET_N pulsed low while in EMIT with 2 packets queued -> acc_valid=0 immediately, in_ready=1, busy=0, no further commands.
